mem_redirect_ctrl: RTL and testbench

//  Consumer of the EX/MEM pipeline register's control-flow and memory fields.
//  - Resolves jump, BEQ and BNE in the MEM stage.
//  - Drives the PC redirect and the flush controls for IF/ID, ID/EX and EX/MEM.
//  - Stalls the pipeline while a data-memory access waits for mem_ready.
//  - Keeps saturating counters of branches taken and not taken.

---
 rtl/mem_redirect_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_redirect_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// mem_redirect_ctrl
//
// Control-flow resolution for the MEM stage of a classic five-stage pipeline.
// Reads the control and memory fields of the EX/MEM register and:
//   - resolves jump, BEQ and BNE, and issues a PC redirect to the target;
//   - flushes IF/ID and ID/EX for SQUASH_CYCLES cycles per redirect, and
//     EX/MEM for the single redirect cycle;
//   - freezes the pipeline while a data-memory access waits for mem_ready;
//   - keeps saturating statistics of taken and not-taken control transfers.
// Every output is registered, so each reacts one cycle after the inputs
// that caused it.
//
// Parameters
//   N             datapath / address width
//   SQUASH_CYCLES cycles flush_if_id / flush_id_ex stay high per redirect (>=1)
//   CNT_W         width of the branch statistics counters
//
// Ports
//   clk             in   1      rising-edge clock
//   reset           in   1      synchronous, active-high reset
//   jump_mem        in   1      Jump from EX/MEM
//   branch_eq_mem   in   1      BranchEQ from EX/MEM
//   branch_ne_mem   in   1      BranchNE from EX/MEM
//   zero_mem        in   1      ALU Zero of the instruction in MEM
//   jump_addr_mem   in   N      jump target from EX/MEM
//   branch_addr_mem in   N      branch target from EX/MEM
//   mem_read_mem    in   1      MemRead from EX/MEM
//   mem_write_mem   in   1      MemWrite from EX/MEM
//   mem_ready       in   1      data memory completes its access this cycle
//   pc_redirect     out  1      load pc_target into the PC (1-cycle pulse)
//   pc_target       out  N      redirect target
//   flush_if_id     out  1      clear IF/ID
//   flush_id_ex     out  1      clear ID/EX
//   flush_ex_mem    out  1      clear EX/MEM (pulses together with pc_redirect)
//   stall           out  1      hold the PC and all pipeline registers
//   taken_cnt       out  CNT_W  taken jumps and branches, saturating
//   not_taken_cnt   out  CNT_W  branches not taken, saturating
// ---------------------------------------------------------------------------
module mem_redirect_ctrl #(
    parameter int N             = 32,
    parameter int SQUASH_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             jump_mem,
    input  logic             branch_eq_mem,
    input  logic             branch_ne_mem,
    input  logic             zero_mem,
    input  logic [N-1:0]     jump_addr_mem,
    input  logic [N-1:0]     branch_addr_mem,
    input  logic             mem_read_mem,
    input  logic             mem_write_mem,
    input  logic             mem_ready,
    output logic             pc_redirect,
    output logic [N-1:0]     pc_target,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             stall,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] not_taken_cnt
);

    // The squash counter only has to hold SQUASH_CYCLES-1; keep it at least
    // one bit wide so the single-cycle configuration still elaborates.
    localparam int              SQ_W    = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;
    localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } state_t;

    // Saturating increment: the statistics stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [SQ_W-1:0]   sq_cnt_r;
    logic [SQ_W-1:0]   sq_cnt_nxt_s;

    logic              take_s;
    logic              cond_branch_s;
    logic              mem_req_s;
    logic [N-1:0]      target_s;

    state_t            res_state_s;
    logic [SQ_W-1:0]   res_sq_cnt_s;
    logic [CNT_W-1:0]  res_taken_cnt_s;
    logic [CNT_W-1:0]  res_not_taken_cnt_s;

    logic              redirect_nxt_s;
    logic              flush_front_nxt_s;
    logic              flush_ex_mem_nxt_s;
    logic              stall_nxt_s;
    logic [N-1:0]      target_nxt_s;
    logic [CNT_W-1:0]  taken_cnt_nxt_s;
    logic [CNT_W-1:0]  not_taken_cnt_nxt_s;

    // Decode the redirect condition, target and memory request of the MEM instruction.
    always_comb begin
        take_s        = jump_mem | (branch_eq_mem & zero_mem) | (branch_ne_mem & ~zero_mem);
        cond_branch_s = branch_eq_mem | branch_ne_mem;
        mem_req_s     = mem_read_mem | mem_write_mem;
        // A jump wins over a branch that happens to be flagged alongside it.
        if (jump_mem) begin
            target_s = jump_addr_mem;
        end else begin
            target_s = branch_addr_mem;
        end
    end

    // Outcome of resolving the MEM instruction; shared by IDLE and by WAIT
    // once the memory access completes, so a waiting access keeps its redirect.
    always_comb begin
        res_state_s         = IDLE;
        res_sq_cnt_s        = '0;
        res_taken_cnt_s     = taken_cnt;
        res_not_taken_cnt_s = not_taken_cnt;
        if (take_s) begin
            res_taken_cnt_s = sat_inc(taken_cnt);
            // With a single squash cycle the redirect cycle itself is the
            // whole squash, so there is no SQUASH state to visit.
            if (SQUASH_CYCLES > 1) begin
                res_state_s  = SQUASH;
                res_sq_cnt_s = SQ_LOAD;
            end else begin
                res_state_s  = IDLE;
                res_sq_cnt_s = '0;
            end
        end else if (cond_branch_s) begin
            res_not_taken_cnt_s = sat_inc(not_taken_cnt);
        end else begin
            res_not_taken_cnt_s = not_taken_cnt;
        end
    end

    // Next-state and next-output logic of the redirect/stall FSM.
    always_comb begin
        state_nxt_s         = state_r;
        sq_cnt_nxt_s        = sq_cnt_r;
        redirect_nxt_s      = 1'b0;
        flush_front_nxt_s   = 1'b0;
        flush_ex_mem_nxt_s  = 1'b0;
        stall_nxt_s         = 1'b0;
        target_nxt_s        = pc_target;
        taken_cnt_nxt_s     = taken_cnt;
        not_taken_cnt_nxt_s = not_taken_cnt;

        case (state_r)
            IDLE, WAIT: begin
                // In WAIT the EX/MEM fields are frozen, so the pending access
                // is implied by the state rather than re-read from mem_req.
                if (((state_r == WAIT) || mem_req_s) && !mem_ready) begin
                    state_nxt_s = WAIT;
                    stall_nxt_s = 1'b1;
                end else begin
                    state_nxt_s         = res_state_s;
                    sq_cnt_nxt_s        = res_sq_cnt_s;
                    redirect_nxt_s      = take_s;
                    flush_front_nxt_s   = take_s;
                    flush_ex_mem_nxt_s  = take_s;
                    taken_cnt_nxt_s     = res_taken_cnt_s;
                    not_taken_cnt_nxt_s = res_not_taken_cnt_s;
                    if (take_s) begin
                        target_nxt_s = target_s;
                    end else begin
                        target_nxt_s = pc_target;
                    end
                end
            end
            SQUASH: begin
                // Instructions seen here are being squashed: their take and
                // memory requests are deliberately ignored.
                if (sq_cnt_r == '0) begin
                    state_nxt_s = IDLE;
                end else begin
                    flush_front_nxt_s = 1'b1;
                    sq_cnt_nxt_s      = sq_cnt_r - SQ_W'(1);
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                sq_cnt_nxt_s = '0;
            end
        endcase
    end

    // FSM state and squash counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            sq_cnt_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            sq_cnt_r <= sq_cnt_nxt_s;
        end
    end

    // Registered outputs and statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_redirect   <= 1'b0;
            pc_target     <= '0;
            flush_if_id   <= 1'b0;
            flush_id_ex   <= 1'b0;
            flush_ex_mem  <= 1'b0;
            stall         <= 1'b0;
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else begin
            pc_redirect   <= redirect_nxt_s;
            pc_target     <= target_nxt_s;
            flush_if_id   <= flush_front_nxt_s;
            flush_id_ex   <= flush_front_nxt_s;
            flush_ex_mem  <= flush_ex_mem_nxt_s;
            stall         <= stall_nxt_s;
            taken_cnt     <= taken_cnt_nxt_s;
            not_taken_cnt <= not_taken_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_redirect_ctrl
//
// Scoreboard bench for mem_redirect_ctrl. Two instances share the stimulus:
//   A: SQUASH_CYCLES = 2, CNT_W = 16  (default configuration)
//   B: SQUASH_CYCLES = 1, CNT_W = 2   (single-cycle squash, fast saturation)
// The driver applies one stimulus per cycle on the falling edge and pushes the
// response predicted by a behavioural model into a per-instance queue; the
// monitor pops one entry after every rising edge and compares all outputs.
// ---------------------------------------------------------------------------
module tb_mem_redirect_ctrl;

    localparam int N    = 32;
    localparam int SQ_A = 2;
    localparam int CW_A = 16;
    localparam int SQ_B = 1;
    localparam int CW_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          jump_mem = 1'b0;
    logic          branch_eq_mem = 1'b0;
    logic          branch_ne_mem = 1'b0;
    logic          zero_mem = 1'b0;
    logic [N-1:0]  jump_addr_mem = '0;
    logic [N-1:0]  branch_addr_mem = '0;
    logic          mem_read_mem = 1'b0;
    logic          mem_write_mem = 1'b0;
    logic          mem_ready = 1'b0;

    logic            a_redirect, a_fif, a_fie, a_fem, a_stall;
    logic [N-1:0]    a_target;
    logic [CW_A-1:0] a_taken, a_ntaken;
    logic            b_redirect, b_fif, b_fie, b_fem, b_stall;
    logic [N-1:0]    b_target;
    logic [CW_B-1:0] b_taken, b_ntaken;

    mem_redirect_ctrl #(.N(N), .SQUASH_CYCLES(SQ_A), .CNT_W(CW_A)) u_a (
        .clk(clk), .reset(reset), .jump_mem(jump_mem), .branch_eq_mem(branch_eq_mem),
        .branch_ne_mem(branch_ne_mem), .zero_mem(zero_mem), .jump_addr_mem(jump_addr_mem),
        .branch_addr_mem(branch_addr_mem), .mem_read_mem(mem_read_mem),
        .mem_write_mem(mem_write_mem), .mem_ready(mem_ready), .pc_redirect(a_redirect),
        .pc_target(a_target), .flush_if_id(a_fif), .flush_id_ex(a_fie),
        .flush_ex_mem(a_fem), .stall(a_stall), .taken_cnt(a_taken), .not_taken_cnt(a_ntaken)
    );

    mem_redirect_ctrl #(.N(N), .SQUASH_CYCLES(SQ_B), .CNT_W(CW_B)) u_b (
        .clk(clk), .reset(reset), .jump_mem(jump_mem), .branch_eq_mem(branch_eq_mem),
        .branch_ne_mem(branch_ne_mem), .zero_mem(zero_mem), .jump_addr_mem(jump_addr_mem),
        .branch_addr_mem(branch_addr_mem), .mem_read_mem(mem_read_mem),
        .mem_write_mem(mem_write_mem), .mem_ready(mem_ready), .pc_redirect(b_redirect),
        .pc_target(b_target), .flush_if_id(b_fif), .flush_id_ex(b_fie),
        .flush_ex_mem(b_fem), .stall(b_stall), .taken_cnt(b_taken), .not_taken_cnt(b_ntaken)
    );

    typedef struct {
        bit          reset, jump, beq, bne, zero;
        logic [31:0] jaddr, baddr;
        bit          mrd, mwr, mready;
    } stim_t;

    // Model state: how many following cycles still belong to a squash,
    // whether an access is outstanding, and the architectural statistics.
    typedef struct {
        int          ignore_left;
        bit          in_wait;
        int          taken;
        int          ntaken;
        logic [31:0] target;
    } mdl_t;

    typedef struct {
        bit          redirect;
        logic [31:0] target;
        bit          fif, fie, fem, stall;
        int          taken, ntaken;
    } exp_t;

    mdl_t ma, mb;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks = 0;
    int   errors = 0;

    // Predicts the outputs visible after the clock edge that samples s.
    function automatic exp_t model_step(inout mdl_t m, input stim_t s, input int sq, input int cmax);
        exp_t e;
        bit   take;
        e.redirect = 1'b0;
        e.fif      = 1'b0;
        e.fie      = 1'b0;
        e.fem      = 1'b0;
        e.stall    = 1'b0;
        take = s.jump || (s.beq && s.zero) || (s.bne && !s.zero);
        if (s.reset) begin
            m.ignore_left = 0;
            m.in_wait     = 1'b0;
            m.taken       = 0;
            m.ntaken      = 0;
            m.target      = 32'h0;
        end else if (m.ignore_left > 0) begin
            // Squash: front flushes persist, the last squash cycle releases them.
            e.fif = (m.ignore_left > 1);
            e.fie = e.fif;
            m.ignore_left--;
        end else if ((m.in_wait || s.mrd || s.mwr) && !s.mready) begin
            m.in_wait = 1'b1;
            e.stall   = 1'b1;
        end else begin
            m.in_wait = 1'b0;
            if (take) begin
                e.redirect = 1'b1;
                e.fif      = 1'b1;
                e.fie      = 1'b1;
                e.fem      = 1'b1;
                m.target   = s.jump ? s.jaddr : s.baddr;
                if (m.taken < cmax) m.taken++;
                m.ignore_left = (sq > 1) ? sq : 0;
            end else if (s.beq || s.bne) begin
                if (m.ntaken < cmax) m.ntaken++;
            end
        end
        e.target = m.target;
        e.taken  = m.taken;
        e.ntaken = m.ntaken;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic check_out(input string side, input exp_t e, input logic redir,
                             input logic [31:0] tgt, input logic fif, input logic fie,
                             input logic fem, input logic stl, input logic [31:0] tk,
                             input logic [31:0] ntk);
        chk({side, " pc_redirect"},   {31'd0, redir}, {31'd0, e.redirect});
        chk({side, " pc_target"},     tgt,            e.target);
        chk({side, " flush_if_id"},   {31'd0, fif},   {31'd0, e.fif});
        chk({side, " flush_id_ex"},   {31'd0, fie},   {31'd0, e.fie});
        chk({side, " flush_ex_mem"},  {31'd0, fem},   {31'd0, e.fem});
        chk({side, " stall"},         {31'd0, stl},   {31'd0, e.stall});
        chk({side, " taken_cnt"},     tk,             32'(e.taken));
        chk({side, " not_taken_cnt"}, ntk,            32'(e.ntaken));
    endtask

    // Monitor: one expected response per rising edge, compared just after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                check_out("A", ea, a_redirect, a_target, a_fif, a_fie, a_fem, a_stall,
                          32'(a_taken), 32'(a_ntaken));
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                check_out("B", eb, b_redirect, b_target, b_fif, b_fie, b_fem, b_stall,
                          32'(b_taken), 32'(b_ntaken));
            end
        end
    end

    function automatic stim_t nop();
        stim_t s;
        s.reset  = 1'b0;
        s.jump   = 1'b0;
        s.beq    = 1'b0;
        s.bne    = 1'b0;
        s.zero   = 1'b0;
        s.jaddr  = 32'h0;
        s.baddr  = 32'h0;
        s.mrd    = 1'b0;
        s.mwr    = 1'b0;
        s.mready = 1'b0;
        return s;
    endfunction

    // Driver: apply one stimulus and queue the predicted response.
    task automatic step(input stim_t s);
        @(negedge clk);
        reset           = s.reset;
        jump_mem        = s.jump;
        branch_eq_mem   = s.beq;
        branch_ne_mem   = s.bne;
        zero_mem        = s.zero;
        jump_addr_mem   = s.jaddr;
        branch_addr_mem = s.baddr;
        mem_read_mem    = s.mrd;
        mem_write_mem   = s.mwr;
        mem_ready       = s.mready;
        qa.push_back(model_step(ma, s, SQ_A, (1 << CW_A) - 1));
        qb.push_back(model_step(mb, s, SQ_B, (1 << CW_B) - 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(nop());
    endtask

    initial begin
        stim_t s;
        ma = '{ignore_left: 0, in_wait: 1'b0, taken: 0, ntaken: 0, target: 32'h0};
        mb = ma;

        // Power-up reset.
        s = nop(); s.reset = 1'b1;
        step(s); step(s);
        idle(1);

        // Reset held three cycles while A is still squashing.
        s = nop(); s.beq = 1'b1; s.zero = 1'b1; s.baddr = 32'h0040_0010;
        step(s);
        idle(1);
        s = nop(); s.reset = 1'b1;
        step(s); step(s); step(s);
        idle(2);

        // Taken BEQ: redirect, two-cycle front flush, taken_cnt = 1.
        s = nop(); s.beq = 1'b1; s.zero = 1'b1; s.baddr = 32'h0040_0020;
        step(s);
        idle(3);

        // Not-taken BNE.
        s = nop(); s.bne = 1'b1; s.zero = 1'b1; s.baddr = 32'h0040_0040;
        step(s);
        idle(1);

        // Jump together with a taken BEQ: jump target wins, counted once.
        s = nop(); s.jump = 1'b1; s.beq = 1'b1; s.zero = 1'b1;
        s.jaddr = 32'h0040_0100; s.baddr = 32'h0040_0300;
        step(s);
        idle(3);

        // Load waits four cycles, no redirect.
        s = nop(); s.mrd = 1'b1;
        for (int i = 0; i < 4; i++) step(s);
        s.mready = 1'b1;
        step(s);
        idle(2);

        // Load waits four cycles with a taken branch: redirect as stall drops.
        s = nop(); s.mrd = 1'b1; s.beq = 1'b1; s.zero = 1'b1; s.baddr = 32'h0040_0200;
        for (int i = 0; i < 4; i++) step(s);
        s.mready = 1'b1;
        step(s);
        idle(3);

        // Five jumps: B saturates its 2-bit taken counter at 3.
        for (int i = 0; i < 5; i++) begin
            s = nop(); s.jump = 1'b1; s.jaddr = 32'h0040_1000 + 32'(i * 16);
            step(s);
            idle(3);
        end

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            s = nop();
            s.reset  = ($urandom_range(0, 63) == 0);
            s.jump   = ($urandom_range(0, 7) == 0);
            s.beq    = ($urandom_range(0, 3) == 0);
            s.bne    = ($urandom_range(0, 3) == 0);
            s.zero   = ($urandom_range(0, 1) == 1);
            s.jaddr  = $urandom;
            s.baddr  = $urandom;
            s.mrd    = ($urandom_range(0, 4) == 0);
            s.mwr    = ($urandom_range(0, 5) == 0);
            s.mready = ($urandom_range(0, 2) != 0);
            step(s);
        end

        idle(2);
        @(posedge clk);
        #2;
        chk("scoreboard drained", 32'(qa.size() + qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
